instruction_fetch_sequencer: RTL

Owns the program counter (PC) and drives the address of the instruction memory (combinational read, contents loaded on the first clock edge). Delivers one instruction per cycle to decode over a valid/ready handshake. Handles stalls, branch redirects, the HALT opcode and out-of-range fetch faults. Sits between the instruction memory and the decode stage.

---
 rtl/instruction_fetch_sequencer_if.sv | 61 ++++++
 rtl/instruction_fetch_sequencer.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch_sequencer_if
// Purpose  : Memory, redirect and decode handshake bundle for the fetch stage.
// Revision : 1.0 - initial release
// ============================================================================
interface instruction_fetch_sequencer_if #(
  parameter int ADDR_WIDTH  = 32,
  parameter int INSTR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]  imem_address;
  logic [INSTR_WIDTH-1:0] imem_data;
  logic                   stall;
  logic                   branch_valid;
  logic [ADDR_WIDTH-1:0]  branch_target;
  logic                   resume;
  logic                   instr_valid;
  logic                   instr_ready;
  logic [INSTR_WIDTH-1:0] instr_out;
  logic [ADDR_WIDTH-1:0]  instr_pc;
  logic                   halted;
  logic                   fault;
  logic [31:0]            fetch_count;
  logic [31:0]            stall_count;

  // master is the fetch sequencer itself
  modport master (
    output imem_address,
    input  imem_data,
    input  stall,
    input  branch_valid,
    input  branch_target,
    input  resume,
    output instr_valid,
    input  instr_ready,
    output instr_out,
    output instr_pc,
    output halted,
    output fault,
    output fetch_count,
    output stall_count
  );

  modport slave (
    input  imem_address,
    output imem_data,
    output stall,
    output branch_valid,
    output branch_target,
    output resume,
    input  instr_valid,
    output instr_ready,
    input  instr_out,
    input  instr_pc,
    input  halted,
    input  fault,
    input  fetch_count,
    input  stall_count
  );
endinterface
`default_nettype wire

// File: rtl/instruction_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch_sequencer
// Purpose  : PC owner; fetches one word per cycle into a valid/ready decode
//            slot with stall, redirect, HALT and out-of-range fault handling.
//            Define FETCH_PERF_COUNTERS_EN to build the fetch/stall counters.
// Revision : 1.0 - initial release
// ============================================================================
module instruction_fetch_sequencer #(
  parameter int                   ADDR_WIDTH  = 32,
  parameter int                   INSTR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                   MEM_DEPTH   = 41,
  parameter int                   INIT_CYCLES = 2,
  parameter logic [4:0]           HALT_OPCODE = 5'b00101
) (
  input  logic                           clock,
  input  logic                           reset,
  instruction_fetch_sequencer_if.master  bus
);

  localparam logic [ADDR_WIDTH-1:0] c_mem_depth = ADDR_WIDTH'(MEM_DEPTH);
  localparam logic [7:0] c_init_last = (INIT_CYCLES > 0) ? 8'(INIT_CYCLES - 1) : 8'd0;

  typedef enum logic [1:0] {
    S_INIT   = 2'd0,
    S_FETCH  = 2'd1,
    S_HALTED = 2'd2,
    S_FAULT  = 2'd3
  } state_t;

  state_t                 r_state;
  logic [7:0]             r_init_cnt;
  logic [ADDR_WIDTH-1:0]  r_pc;
  logic [ADDR_WIDTH-1:0]  r_instr_pc;
  logic [INSTR_WIDTH-1:0] r_instr_out;
  logic                   r_instr_valid;
  logic                   r_halted;
  logic                   r_fault;

  logic w_consumed;
  logic w_fetch_go;
  logic w_pc_oob;
  logic w_is_halt;

  assign w_consumed = r_instr_valid && bus.instr_ready;
  assign w_fetch_go = (r_state == S_FETCH) && !bus.stall && !bus.branch_valid
                      && (!r_instr_valid || bus.instr_ready);
  assign w_pc_oob   = (r_pc >= c_mem_depth);
  assign w_is_halt  = (bus.imem_data[INSTR_WIDTH-1 -: 5] == HALT_OPCODE);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= S_INIT;
      r_init_cnt    <= 8'd0;
      r_pc          <= RESET_PC;
      r_instr_pc    <= '0;
      r_instr_out   <= '0;
      r_instr_valid <= 1'b0;
      r_halted      <= 1'b0;
      r_fault       <= 1'b0;
    end else begin
      case (r_state)
        S_INIT: begin
          if (r_init_cnt == c_init_last) begin
            r_state <= S_FETCH;
          end else begin
            r_init_cnt <= r_init_cnt + 8'd1;
          end
        end
        S_FETCH: begin
          // a redirect flushes the slot even if decode is taking it this cycle
          if (bus.branch_valid) begin
            r_pc          <= bus.branch_target;
            r_instr_valid <= 1'b0;
          end else if (w_fetch_go) begin
            if (w_pc_oob) begin
              r_fault       <= 1'b1;
              r_state       <= S_FAULT;
              r_instr_valid <= 1'b0;
            end else begin
              r_instr_out   <= bus.imem_data;
              r_instr_pc    <= r_pc;
              r_instr_valid <= 1'b1;
              r_pc          <= r_pc + 1'b1;
              if (w_is_halt) begin
                r_state  <= S_HALTED;
                r_halted <= 1'b1;
              end
            end
          end else if (w_consumed) begin
            r_instr_valid <= 1'b0;
          end
        end
        S_HALTED: begin
          if (w_consumed) begin
            r_instr_valid <= 1'b0;
          end
          if (bus.resume) begin
            r_state  <= S_FETCH;
            r_halted <= 1'b0;
          end
        end
        default: begin
          if (w_consumed) begin
            r_instr_valid <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.imem_address = r_pc;
  assign bus.instr_valid  = r_instr_valid;
  assign bus.instr_out    = r_instr_out;
  assign bus.instr_pc     = r_instr_pc;
  assign bus.halted       = r_halted;
  assign bus.fault        = r_fault;

`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] r_fetch_count;
  logic [31:0] r_stall_count;
  logic        w_load;
  logic        w_stall_cycle;

  assign w_load        = w_fetch_go && !w_pc_oob;
  assign w_stall_cycle = (r_state == S_FETCH) && bus.stall && !bus.branch_valid;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_fetch_count <= 32'd0;
      r_stall_count <= 32'd0;
    end else begin
      if (w_load && (r_fetch_count != 32'hFFFF_FFFF)) begin
        r_fetch_count <= r_fetch_count + 32'd1;
      end
      if (w_stall_cycle && (r_stall_count != 32'hFFFF_FFFF)) begin
        r_stall_count <= r_stall_count + 32'd1;
      end
    end
  end

  assign bus.fetch_count = r_fetch_count;
  assign bus.stall_count = r_stall_count;
`else
  assign bus.fetch_count = 32'd0;
  assign bus.stall_count = 32'd0;
`endif

endmodule
`default_nettype wire
